// File: rtl/custom_instr_pkg.sv
// Shared encodings for the custom-instruction offload path.
// Holds the opcode, the default X-interface id width and the sequencer states.
package custom_instr_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned XIF_ID_WIDTH = 4;
  localparam int unsigned RD_WIDTH     = 5;

  // custom-0 major opcode carries the CNTB instruction
  localparam logic [6:0] OPCODE_CNTB = 7'b0001011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    HOLD   = 2'd2,
    RESULT = 2'd3
  } custom_seq_state_e;

endpackage

// File: rtl/custom_xif_seq.sv
// X-interface sequencer: takes one offloaded instruction, runs the custom execution
// unit, parks the result until commit/kill and returns it on the result channel.
module custom_xif_seq
  import custom_instr_pkg::*;
#(
  parameter int unsigned ID_WIDTH       = XIF_ID_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [XLEN-1:0]     issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]     issue_rs0_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [1:0]          issue_rs_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                exu_start_o,
  output logic [XLEN-1:0]     exu_rs0_o,
  output logic [XLEN-1:0]     exu_rs1_o,
  input  logic                exu_done_i,
  input  logic [XLEN-1:0]     exu_result_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [RD_WIDTH-1:0] result_rd_o,
  output logic                result_we_o,
  output logic                result_err_o,
  output logic                busy_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  custom_seq_state_e state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [RD_WIDTH-1:0] rd_q, rd_d;
  logic [XLEN-1:0]     rs0_q, rs0_d;
  logic [XLEN-1:0]     rs1_q, rs1_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic                err_q, err_d;
  logic                committed_q, committed_d;
  logic                killed_q, killed_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_q, start_d;

  logic accept_c;
  logic issue_hit_c;
  logic commit_hit_c;
  logic kill_now_c;
  logic commit_now_c;
  logic finish_c;
  logic unused_instr_c;

  assign issue_ready_o     = (state_q == IDLE) & (&issue_rs_valid_i);
  assign accept_c          = issue_valid_i & issue_ready_o & (issue_instr_i[6:0] == OPCODE_CNTB);
  assign issue_accept_o    = accept_c;
  assign issue_writeback_o = accept_c;

  // a commit racing the issue handshake is matched against the incoming id
  assign issue_hit_c  = commit_valid_i & (commit_id_i == issue_id_i);
  assign commit_hit_c = commit_valid_i & (commit_id_i == id_q);
  assign kill_now_c   = commit_hit_c & commit_kill_i;
  assign commit_now_c = commit_hit_c & ~commit_kill_i;
  assign finish_c     = exu_done_i | (cnt_q == CNT_LAST);

  assign unused_instr_c = ^issue_instr_i[XLEN-1:12];

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    rd_d        = rd_q;
    rs0_d       = rs0_q;
    rs1_d       = rs1_q;
    data_d      = data_q;
    err_d       = err_q;
    committed_d = committed_q;
    killed_d    = killed_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          id_d        = issue_id_i;
          rd_d        = issue_instr_i[11:7];
          rs0_d       = issue_rs0_i;
          rs1_d       = issue_rs1_i;
          committed_d = issue_hit_c & ~commit_kill_i;
          killed_d    = issue_hit_c & commit_kill_i;
          cnt_d       = '0;
          start_d     = 1'b1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        cnt_d       = cnt_q + CNT_W'(1);
        committed_d = committed_q | commit_now_c;
        killed_d    = killed_q | kill_now_c;
        // watchdog expiry is treated as a completion carrying an error
        if (finish_c) begin
          data_d = exu_done_i ? exu_result_i : '0;
          err_d  = ~exu_done_i;
          if (killed_q | kill_now_c) begin
            state_d = IDLE;
          end else if (committed_q | commit_now_c) begin
            state_d = RESULT;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (commit_hit_c) begin
          committed_d = ~commit_kill_i;
          killed_d    = commit_kill_i;
          state_d     = commit_kill_i ? IDLE : RESULT;
        end
      end
      RESULT: begin
        if (result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      id_q        <= '0;
      rd_q        <= '0;
      rs0_q       <= '0;
      rs1_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      committed_q <= 1'b0;
      killed_q    <= 1'b0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      rd_q        <= rd_d;
      rs0_q       <= rs0_d;
      rs1_q       <= rs1_d;
      data_q      <= data_d;
      err_q       <= err_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
    end
  end

  assign exu_start_o    = start_q;
  assign exu_rs0_o      = rs0_q;
  assign exu_rs1_o      = rs1_q;
  assign busy_o         = (state_q != IDLE);
  assign result_valid_o = (state_q == RESULT);
  assign result_we_o    = (state_q == RESULT) & ~err_q;
  assign result_err_o   = (state_q == RESULT) & err_q;
  assign result_id_o    = id_q;
  assign result_data_o  = data_q;
  assign result_rd_o    = rd_q;

endmodule

// File: tb/tb_custom_xif_seq.sv
// Self-checking bench for custom_xif_seq: directed scenarios plus randomized
// transactions checked against a timeline model of issue/commit/done/ready.
module tb_custom_xif_seq;

  localparam int unsigned IDW = 4;
  localparam int unsigned TO  = 8;
  localparam logic [6:0] CNTB = custom_instr_pkg::OPCODE_CNTB;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           issue_valid_i;
  logic           issue_ready_o;
  logic [31:0]    issue_instr_i;
  logic [IDW-1:0] issue_id_i;
  logic [31:0]    issue_rs0_i;
  logic [31:0]    issue_rs1_i;
  logic [1:0]     issue_rs_valid_i;
  logic           issue_accept_o;
  logic           issue_writeback_o;
  logic           commit_valid_i;
  logic [IDW-1:0] commit_id_i;
  logic           commit_kill_i;
  logic           exu_start_o;
  logic [31:0]    exu_rs0_o;
  logic [31:0]    exu_rs1_o;
  logic           exu_done_i;
  logic [31:0]    exu_result_i;
  logic           result_valid_o;
  logic           result_ready_i;
  logic [IDW-1:0] result_id_o;
  logic [31:0]    result_data_o;
  logic [4:0]     result_rd_o;
  logic           result_we_o;
  logic           result_err_o;
  logic           busy_o;

  int vectors    = 0;
  int miscompares = 0;

  // {issue_ready, busy, exu_start, result_valid, result_we, result_err}
  logic [5:0] ctl;
  assign ctl = {issue_ready_o, busy_o, exu_start_o, result_valid_o, result_we_o, result_err_o};

  always #5 clk_i = ~clk_i;

  custom_xif_seq #(.ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
    .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(issue_accept_o),
    .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .exu_start_o(exu_start_o), .exu_rs0_o(exu_rs0_o), .exu_rs1_o(exu_rs1_o),
    .exu_done_i(exu_done_i), .exu_result_i(exu_result_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .result_err_o(result_err_o), .busy_o(busy_o)
  );

  task automatic quiet();
    issue_valid_i    = 1'b0;
    issue_instr_i    = '0;
    issue_id_i       = '0;
    issue_rs0_i      = '0;
    issue_rs1_i      = '0;
    issue_rs_valid_i = 2'b11;
    commit_valid_i   = 1'b0;
    commit_id_i      = '0;
    commit_kill_i    = 1'b0;
    exu_done_i       = 1'b0;
    exu_result_i     = '0;
    result_ready_i   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [IDW-1:0] id,
                       input logic [31:0] rs0, input logic [31:0] rs1);
    issue_valid_i = 1'b1;
    issue_instr_i = instr;
    issue_id_i    = id;
    issue_rs0_i   = rs0;
    issue_rs1_i   = rs1;
  endtask

  task automatic test_reset();
    quiet();
    rst_i = 1'b1;
    #2;
    vectors++;
    if (ctl !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b100000);
    end
    vectors++;
    if ({exu_rs0_o, exu_rs1_o, result_id_o, result_data_o, result_rd_o, issue_accept_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h/%h/%h/%h expected all zero",
               exu_rs0_o, exu_rs1_o, result_id_o, result_data_o, result_rd_o);
    end
    issue_rs_valid_i = 2'b10;
    #1;
    vectors++;
    if (issue_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_rsvalid: got %b expected 0", issue_ready_o);
    end
    issue_rs_valid_i = 2'b11;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_same_cycle_commit();
    issue({20'h12345, 5'd9, CNTB}, 4'd3, 32'hF000_0000, 32'd31);
    commit_valid_i = 1'b1; commit_id_i = 4'd3; commit_kill_i = 1'b0;
    #1;
    vectors++;
    if ({issue_accept_o, issue_writeback_o, ctl} !== {2'b11, 6'b100000}) begin
      miscompares++;
      $display("FAIL scc_issue: got %b expected %b", {issue_accept_o, issue_writeback_o, ctl}, {2'b11, 6'b100000});
    end
    step();
    quiet();
    exu_done_i = 1'b1; exu_result_i = 32'd4;
    #1;
    vectors++;
    if ({ctl, exu_rs0_o, exu_rs1_o} !== {6'b011000, 32'hF000_0000, 32'd31}) begin
      miscompares++;
      $display("FAIL scc_exec: got %b %h %h expected 011000 f0000000 0000001f", ctl, exu_rs0_o, exu_rs1_o);
    end
    step();
    quiet();
    result_ready_i = 1'b1;
    #1;
    vectors++;
    if ({ctl, result_id_o, result_data_o, result_rd_o} !== {6'b010110, 4'd3, 32'd4, 5'd9}) begin
      miscompares++;
      $display("FAIL scc_result: got %b id=%h data=%h rd=%0d expected 010110 id=3 data=4 rd=9",
               ctl, result_id_o, result_data_o, result_rd_o);
    end
    step();
    quiet();
    #1;
    vectors++;
    if (ctl !== 6'b100000) begin
      miscompares++;
      $display("FAIL scc_idle: got %b expected 100000", ctl);
    end
    step();
  endtask

  task automatic test_hold();
    issue({20'h0, 5'd17, CNTB}, 4'd5, 32'h1, 32'h2);
    #1;
    step();
    quiet();
    exu_done_i = 1'b1; exu_result_i = 32'h1234;
    #1;
    step();
    for (int k = 2; k <= 6; k++) begin
      quiet();
      if (k == 3) begin exu_done_i = 1'b1; exu_result_i = 32'hDEAD; end
      if (k == 4) begin commit_valid_i = 1'b1; commit_id_i = 4'd6; end
      if (k == 6) begin commit_valid_i = 1'b1; commit_id_i = 4'd5; end
      #1;
      vectors++;
      if (ctl !== 6'b010000) begin
        miscompares++;
        $display("FAIL hold_wait cyc %0d: got %b expected 010000", k, ctl);
      end
      step();
    end
    quiet();
    result_ready_i = 1'b1;
    #1;
    vectors++;
    if ({ctl, result_id_o, result_data_o, result_rd_o} !== {6'b010110, 4'd5, 32'h1234, 5'd17}) begin
      miscompares++;
      $display("FAIL hold_result: got %b id=%h data=%h rd=%0d expected 010110 id=5 data=1234 rd=17",
               ctl, result_id_o, result_data_o, result_rd_o);
    end
    step();
    quiet();
    step();
  endtask

  task automatic test_kill();
    logic [5:0] exp;
    issue({20'h0, 5'd1, CNTB}, 4'd7, 32'h0, 32'h0);
    #1;
    step();
    for (int k = 1; k <= 5; k++) begin
      quiet();
      if (k == 2) begin commit_valid_i = 1'b1; commit_id_i = 4'd7; commit_kill_i = 1'b1; end
      if (k == 3) begin exu_done_i = 1'b1; exu_result_i = 32'h77; end
      result_ready_i = 1'b1;
      exp = (k == 1) ? 6'b011000 : (k <= 3) ? 6'b010000 : 6'b100000;
      #1;
      vectors++;
      if (ctl !== exp) begin
        miscompares++;
        $display("FAIL kill cyc %0d: got %b expected %b", k, ctl, exp);
      end
      step();
    end
    quiet();
  endtask

  task automatic test_unsupported();
    issue({20'hFFFFF, 5'd3, 7'h33}, 4'd1, 32'h5, 32'h6);
    #1;
    vectors++;
    if ({issue_accept_o, issue_writeback_o, issue_ready_o} !== 3'b001) begin
      miscompares++;
      $display("FAIL unsup_issue: got %b expected 001", {issue_accept_o, issue_writeback_o, issue_ready_o});
    end
    step();
    quiet();
    #1;
    vectors++;
    if (ctl !== 6'b100000) begin
      miscompares++;
      $display("FAIL unsup_after: got %b expected 100000", ctl);
    end
    step();
  endtask

  task automatic test_timeout();
    logic [5:0] exp;
    issue({20'h0, 5'd30, CNTB}, 4'd2, 32'h9, 32'h9);
    #1;
    step();
    for (int k = 1; k <= TO; k++) begin
      quiet();
      if (k == 2) begin commit_valid_i = 1'b1; commit_id_i = 4'd2; end
      exp = (k == 1) ? 6'b011000 : 6'b010000;
      #1;
      vectors++;
      if (ctl !== exp) begin
        miscompares++;
        $display("FAIL timeout_exec cyc %0d: got %b expected %b", k, ctl, exp);
      end
      step();
    end
    quiet();
    result_ready_i = 1'b1;
    #1;
    vectors++;
    if ({ctl, result_id_o, result_data_o, result_rd_o} !== {6'b010101, 4'd2, 32'd0, 5'd30}) begin
      miscompares++;
      $display("FAIL timeout_result: got %b id=%h data=%h rd=%0d expected 010101 id=2 data=0 rd=30",
               ctl, result_id_o, result_data_o, result_rd_o);
    end
    step();
    quiet();
    step();
  endtask

  task automatic test_backpressure_reset();
    issue({20'h0, 5'd12, CNTB}, 4'hA, 32'h3, 32'h4);
    commit_valid_i = 1'b1; commit_id_i = 4'hA;
    #1;
    step();
    quiet();
    exu_done_i = 1'b1; exu_result_i = 32'h55;
    #1;
    step();
    for (int k = 2; k <= 5; k++) begin
      quiet();
      issue({20'h0, 5'd4, CNTB}, 4'h1, 32'hAA, 32'hBB);
      #1;
      vectors++;
      if ({ctl, issue_accept_o, result_id_o, result_data_o, result_rd_o} !== {6'b010110, 1'b0, 4'hA, 32'h55, 5'd12}) begin
        miscompares++;
        $display("FAIL bp_stall cyc %0d: got %b acc=%b id=%h data=%h rd=%0d expected 010110 acc=0 id=a data=55 rd=12",
                 k, ctl, issue_accept_o, result_id_o, result_data_o, result_rd_o);
      end
      if (k < 5) step();
    end
    quiet();
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if ({ctl, exu_rs0_o, exu_rs1_o, result_id_o, result_data_o, result_rd_o} !== {6'b100000, 105'd0}) begin
      miscompares++;
      $display("FAIL bp_async_reset: got %b id=%h data=%h rd=%0d rs0=%h expected 100000 and zero data",
               ctl, result_id_o, result_data_o, result_rd_o, exu_rs0_o);
    end
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // Model: completion time e = done cycle or watchdog cycle, commit time c; the
  // instruction resolves at max(c,e)+1 and, if not killed, waits r cycles for ready.
  task automatic test_random();
    logic [IDW-1:0] id;
    logic [31:0] rs0, rs1, res, tmp, instr;
    logic [4:0] rd;
    logic kill, done_en, stray, exp_rv;
    int c, d, e, r, t_res, hs, last;
    logic [5:0] exp;
    for (int n = 0; n < 40; n++) begin
      id = IDW'($urandom); rs0 = $urandom; rs1 = $urandom; res = $urandom;
      tmp = $urandom; rd = 5'($urandom);
      instr = {tmp[31:12], rd, CNTB};
      c = $urandom_range(0, 7); kill = ($urandom_range(0, 3) == 0);
      done_en = ($urandom_range(0, 4) != 0); d = $urandom_range(1, 6); r = $urandom_range(0, 3);
      e = done_en ? d : TO;
      t_res = ((c > e) ? c : e) + 1;
      hs = t_res + r;
      last = kill ? t_res : hs + 1;
      stray = (e < c);
      for (int k = 0; k <= last; k++) begin
        quiet();
        if (k < last) begin
          tmp = $urandom;
          issue({tmp[31:7], CNTB}, IDW'($urandom), $urandom, $urandom);
        end
        if (k == 0) issue(instr, id, rs0, rs1);
        if (k == c) begin
          commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
        end else begin
          commit_valid_i = ($urandom_range(0, 2) == 0);
          commit_id_i    = id ^ IDW'($urandom_range(1, (1 << IDW) - 1));
          commit_kill_i  = 1'($urandom);
        end
        if (done_en && k == d) begin exu_done_i = 1'b1; exu_result_i = res; end
        if (stray && k == e + 1) begin exu_done_i = 1'b1; exu_result_i = $urandom; end
        result_ready_i = (k < t_res) ? 1'($urandom) : (!kill && k == hs);
        exp_rv = !kill && k >= t_res && k <= hs;
        exp = {(k == 0 || k == last), !(k == 0 || k == last), (k == 1), exp_rv,
               exp_rv && done_en, exp_rv && !done_en};
        #1;
        vectors++;
        if (ctl !== exp) begin
          miscompares++;
          $display("FAIL rnd_ctl txn %0d cyc %0d (c=%0d e=%0d kill=%b r=%0d): got %b expected %b",
                   n, k, c, e, kill, r, ctl, exp);
        end
        if (k == 0) begin
          vectors++;
          if (issue_accept_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rnd_accept txn %0d: got %b expected 1", n, issue_accept_o);
          end
        end
        if (k >= 1 && k < last) begin
          vectors++;
          if ({exu_rs0_o, exu_rs1_o} !== {rs0, rs1}) begin
            miscompares++;
            $display("FAIL rnd_operands txn %0d cyc %0d: got %h %h expected %h %h",
                     n, k, exu_rs0_o, exu_rs1_o, rs0, rs1);
          end
        end
        if (exp_rv) begin
          vectors++;
          if ({result_id_o, result_data_o, result_rd_o} !== {id, (done_en ? res : 32'd0), rd}) begin
            miscompares++;
            $display("FAIL rnd_result txn %0d cyc %0d: got id=%h data=%h rd=%0d expected id=%h data=%h rd=%0d",
                     n, k, result_id_o, result_data_o, result_rd_o, id, (done_en ? res : 32'd0), rd);
          end
        end
        step();
      end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_same_cycle_commit();
    test_hold();
    test_kill();
    test_unsupported();
    test_timeout();
    test_backpressure_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
